// File: rtl/ram_loadable.sv
// Single-clock synchronous RAM with a CPU read/write port, a valid/ready loader port and an
// optional zero-fill sweep after reset. Define RAM_PARITY_EN to store and check a parity bit.
module ram_loadable #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned RAM_DEPTH      = 2 ** ADDR_WIDTH,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic [ADDR_WIDTH:0]   ld_count,
    output logic                  init_done,
    output logic                  parity_err
);

`ifdef RAM_PARITY_EN
    localparam int unsigned MemWidth = DATA_WIDTH + 1;
`else
    localparam int unsigned MemWidth = DATA_WIDTH;
`endif

    localparam logic [ADDR_WIDTH:0]   Depth    = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic {StInit, StReady} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q;
    logic [ADDR_WIDTH:0]     ld_count_q;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [MemWidth-1:0]     wr_word;
    logic [MemWidth-1:0]     rd_word;
    logic                    cpu_in_range;
    logic                    ld_in_range;
    logic                    ld_fire;

    logic [MemWidth-1:0] mem [RAM_DEPTH];

    function automatic logic [MemWidth-1:0] encode(input logic [DATA_WIDTH-1:0] d);
`ifdef RAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    assign init_done    = (state_q == StReady);
    assign ld_ready     = init_done & ~cpu_we;
    assign ld_fire      = ld_valid & ld_ready;
    assign cpu_in_range = ({1'b0, cpu_addr} < Depth);
    assign ld_in_range  = ({1'b0, ld_addr} < Depth);
    assign rd_word      = mem[cpu_addr];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_addr = cpu_addr;
        wr_word = '0;
        if (state_q == StInit) begin
            wr_en   = 1'b1;
            wr_addr = ptr_q;
            ptr_d   = ptr_q + 1'b1;
            if (ptr_q == LastAddr) begin
                state_d = StReady;
            end
        end else if (cpu_we) begin
            wr_en   = cpu_in_range;
            wr_word = encode(cpu_wdata);
        end else if (ld_fire) begin
            // Out-of-range loader writes still handshake and count, but do not store.
            wr_en   = ld_in_range;
            wr_addr = ld_addr;
            wr_word = encode(ld_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? StInit : StReady;
            ptr_q       <= '0;
            cpu_rdata_q <= '0;
            ld_count_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (init_done && cpu_in_range) begin
                cpu_rdata_q <= rd_word[DATA_WIDTH-1:0];
            end else begin
                cpu_rdata_q <= '0;
            end
            if (ld_fire && (ld_count_q != Depth)) begin
                ld_count_q <= ld_count_q + 1'b1;
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= init_done && cpu_in_range &&
                            (rd_word[DATA_WIDTH] != ^rd_word[DATA_WIDTH-1:0]);
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign cpu_rdata = cpu_rdata_q;
    assign ld_count  = ld_count_q;

endmodule

// File: tb/tb_ram_loadable.sv
// Testbench for ram_loadable: 16x8 clearing instance checked against a behavioural model,
// plus a 12-word non-clearing instance for out-of-range and reset-retention cases.
module tb_ram_loadable;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_we = 1'b0;
    logic [3:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic       ld_valid = 1'b0;
    logic [3:0] ld_addr = '0;
    logic [7:0] ld_data = '0;

    logic [7:0] rdata0, rdata1;
    logic       ready0, ready1, done0, done1, perr0, perr1;
    logic [4:0] count0, count1;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_loadable #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RAM_DEPTH(16), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(rdata0), .ld_valid(ld_valid), .ld_ready(ready0), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_count(count0), .init_done(done0), .parity_err(perr0)
    );

    ram_loadable #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RAM_DEPTH(12), .CLEAR_ON_RESET(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(rdata1), .ld_valid(ld_valid), .ld_ready(ready1), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_count(count1), .init_done(done1), .parity_err(perr1)
    );

    // Reference model of the 16-word clearing instance.
    logic [7:0] m_mem [16];
    logic [7:0] m_rdata;
    int         m_count;
    int         m_sweep_left;
    logic       last_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_rdata      = '0;
        m_count      = 0;
        m_sweep_left = 16;
    endtask

    task automatic m_update();
        if (!rst_n) begin
            m_reset();
        end else if (m_sweep_left > 0) begin
            m_mem[16 - m_sweep_left] = '0;
            m_sweep_left--;
            m_rdata = '0;
        end else begin
            m_rdata = m_mem[cpu_addr];
            if (cpu_we) begin
                m_mem[cpu_addr] = cpu_wdata;
            end else if (ld_valid) begin
                m_mem[ld_addr] = ld_data;
                if (m_count < 16) m_count++;
            end
        end
    endtask

    // Inputs must already be set; checks comb outputs, clocks once, checks registered outputs.
    task automatic step();
        logic exp_ready;
        #1;
        exp_ready = (m_sweep_left == 0) && !cpu_we;
        chk("ld_ready", {31'b0, ready0}, {31'b0, exp_ready});
        last_stall = ld_valid && !exp_ready;
        @(posedge clk);
        m_update();
        #1;
        chk("cpu_rdata", {24'b0, rdata0}, {24'b0, m_rdata});
        chk("ld_count", {27'b0, count0}, m_count);
        chk("init_done", {31'b0, done0}, {31'b0, (m_sweep_left == 0)});
        chk("parity_err", {31'b0, perr0}, 32'd0);
    endtask

    task automatic dump();
        for (int i = 0; i < 16; i++) begin
            $display("mem[%0d] = %h", i, dut0.mem[i]);
        end
    endtask

    typedef struct {
        logic       we;
        logic [3:0] a;
        logic [7:0] wd;
        logic       lv;
        logic [3:0] la;
        logic [7:0] ld;
        logic       exp_ready;
        logic [7:0] exp_rdata;
        logic [4:0] exp_count;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 4'h3, 8'h86, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 5'd0};
        tbl[1] = '{1'b0, 4'h3, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 8'h86, 5'd0};
        tbl[2] = '{1'b1, 4'h3, 8'h11, 1'b0, 4'h0, 8'h00, 1'b0, 8'h86, 5'd0};
        tbl[3] = '{1'b0, 4'h3, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 8'h11, 5'd0};
        tbl[4] = '{1'b1, 4'h9, 8'h22, 1'b1, 4'h7, 8'h5c, 1'b0, 8'h00, 5'd0};
        tbl[5] = '{1'b1, 4'h9, 8'h22, 1'b1, 4'h7, 8'h5c, 1'b0, 8'h22, 5'd0};
        tbl[6] = '{1'b0, 4'h7, 8'h00, 1'b1, 4'h7, 8'h5c, 1'b1, 8'h00, 5'd1};
        tbl[7] = '{1'b0, 4'h7, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 8'h5c, 5'd1};
        tbl[8] = '{1'b0, 4'h9, 8'h00, 1'b1, 4'hf, 8'he1, 1'b1, 8'h22, 5'd2};
        tbl[9] = '{1'b0, 4'hf, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 8'he1, 5'd2};
        last_stall = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        chk("rst cpu_rdata", {24'b0, rdata0}, 32'd0);
        chk("rst ld_count", {27'b0, count0}, 32'd0);
        chk("rst init_done", {31'b0, done0}, 32'd0);
        chk("rst parity_err", {31'b0, perr0}, 32'd0);
        chk("rst noclear init_done", {31'b0, done1}, 32'd1);

        // Sweep with CPU writes that must be ignored, then read back all zeros
        rst_n = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 4'h0;
        cpu_wdata = 8'hff;
        for (int i = 0; i < 16; i++) step();
        chk("sweep done after 16", {31'b0, done0}, 32'd1);
        cpu_we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cpu_addr = 4'(i);
            step();
        end

        // Directed vectors: read-before-write, CPU priority, loader transfers
        for (int i = 0; i < 10; i++) begin
            cpu_we = tbl[i].we;
            cpu_addr = tbl[i].a;
            cpu_wdata = tbl[i].wd;
            ld_valid = tbl[i].lv;
            ld_addr = tbl[i].la;
            ld_data = tbl[i].ld;
            #1;
            chk($sformatf("vec%0d ld_ready", i), {31'b0, ready0}, {31'b0, tbl[i].exp_ready});
            @(posedge clk);
            m_update();
            #1;
            chk($sformatf("vec%0d cpu_rdata", i), {24'b0, rdata0}, {24'b0, tbl[i].exp_rdata});
            chk($sformatf("vec%0d ld_count", i), {27'b0, count0}, {27'b0, tbl[i].exp_count});
        end

        // Saturation of ld_count
        cpu_we = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ld_addr = 4'(i);
            ld_data = 8'(i * 7 + 1);
            step();
        end
        chk("ld_count saturated", {27'b0, count0}, 32'd16);
        ld_valid = 1'b0;

        // Reset while the sweep is at pointer 7
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("restart sweep not done at 15", {31'b0, done0}, 32'd0);
        step();
        chk("restart sweep done at 16", {31'b0, done0}, 32'd1);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 119) != 0);
            cpu_we = ($urandom_range(0, 3) == 0);
            cpu_addr = 4'($urandom);
            cpu_wdata = 8'($urandom);
            if (!last_stall) begin
                ld_valid = ($urandom_range(0, 1) == 0);
                ld_addr = 4'($urandom);
                ld_data = 8'($urandom);
            end
            step();
        end
        rst_n = 1'b1;
        cpu_we = 1'b0;
        ld_valid = 1'b0;
        for (int i = 0; i < 16; i++) step();

        // Non-clearing instance: contents survive reset, out-of-range handling
        cpu_we = 1'b1;
        cpu_addr = 4'h2;
        cpu_wdata = 8'ha5;
        step();
        cpu_we = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("noclear init_done after reset", {31'b0, done1}, 32'd1);
        chk("noclear ld_count after reset", {27'b0, count1}, 32'd0);
        ld_valid = 1'b1;
        ld_addr = 4'he;
        ld_data = 8'h33;
        #1;
        chk("noclear ld_ready", {31'b0, ready1}, 32'd1);
        step();
        chk("noclear out-of-range load counts", {27'b0, count1}, 32'd1);
        ld_valid = 1'b0;
        cpu_addr = 4'he;
        step();
        chk("noclear out-of-range read", {24'b0, rdata1}, 32'd0);
        cpu_addr = 4'h2;
        step();
        chk("noclear retained data", {24'b0, rdata1}, 32'ha5);
        for (int i = 0; i < 14; i++) step();

`ifdef RAM_PARITY_EN
        cpu_we = 1'b1;
        cpu_addr = 4'h5;
        cpu_wdata = 8'h0f;
        step();
        cpu_we = 1'b0;
        dut0.mem[5][8] = ~dut0.mem[5][8];
        @(posedge clk);
        #1;
        chk("parity bad read rdata", {24'b0, rdata0}, 32'h0f);
        chk("parity bad read flag", {31'b0, perr0}, 32'd1);
        cpu_addr = 4'h3;
        @(posedge clk);
        #1;
        chk("parity clean read flag", {31'b0, perr0}, 32'd0);
`endif

        dump();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
